// File: rtl/stopwatch_ctrl_pkg.sv
// Shared constants and types for the stopwatch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package stopwatch_ctrl_pkg;

  // FSM state encodings, also visible on the state output
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;

  // Per-digit roll-over limits
  localparam logic [3:0] CS_MAX       = 4'd9;
  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Divider constants: the 100 Hz tick is produced upstream from the
  // crystal clock; the count spans 6000 centiseconds before wrapping.
  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned TICK_HZ    = 100;
  localparam int unsigned TICK_DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned CS_PER_MIN = 6000;

  // Display word layout, most significant digit first
  typedef struct packed {
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] cs_tens;
    logic [3:0] cs_ones;
  } bcd_time_t;

  // True in the states where ticks advance the count
  function automatic logic is_counting(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_cnt.sv
// Single BCD digit counter with programmable maximum and carry out.
// Latency: value updates on the clk edge after enable; carry is combinational.
// Backpressure: none; the enable is a one-cycle qualifier, never stalled.
module bcd_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic [3:0] i_max,
  output logic [3:0] o_val,
  output logic       o_carry
);

  logic [3:0] r_val;
  logic       w_at_max;

  // ">=" rather than "==" so a digit can never get stuck above its limit
  assign w_at_max = (r_val >= i_max);

  // Carry fires only on the increment that rolls this digit over;
  // a clear always wins so it can never ripple into the next digit.
  assign o_carry = i_en & w_at_max & ~i_clr;

  assign o_val = r_val;

  // Digit register: clear has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= 4'd0;
    end else if (i_clr) begin
      r_val <= 4'd0;
    end else if (i_en) begin
      r_val <= w_at_max ? 4'd0 : (r_val + 4'd1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button FSM, 00.00-59.99 BCD count, lap-freeze display.
// Latency: state 1 clk after button edge; disp_bcd 1 clk behind live count.
// Backpressure: none; ticks and button edges are consumed every cycle.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_100,
  input  logic        btn_ss,
  input  logic        btn_lr,
  output logic [15:0] disp_bcd,
  output logic [1:0]  state,
  output logic        running,
  output logic        wrap
);

  // Button edge detection
  logic       r_ss_q;
  logic       r_lr_q;
  logic       w_ss_edge;
  logic       w_lr_edge;

  // FSM
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;

  // Counter chain
  logic       w_cnt_en;
  logic       w_cnt_clr;
  logic       w_c_cs_ones;
  logic       w_c_cs_tens;
  logic       w_c_sec_ones;
  logic       w_c_sec_tens;
  bcd_time_t  w_count;

  // Outputs
  logic [15:0] r_disp;
  logic        r_wrap;

  assign w_ss_edge = btn_ss & ~r_ss_q;
  assign w_lr_edge = btn_lr & ~r_lr_q;

  // Previous button levels; reset to 0 so a button held through reset
  // is seen as one fresh press on the first clock afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_q <= 1'b0;
      r_lr_q <= 1'b0;
    end else begin
      r_ss_q <= btn_ss;
      r_lr_q <= btn_lr;
    end
  end

  // Next-state decode; start/stop is checked first in every state so a
  // coincident lap/reset edge is simply dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_edge) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_ss_edge)      w_state_nxt = ST_PAUSE;
        else if (w_lr_edge) w_state_nxt = ST_LAP;
      end
      ST_LAP: begin
        if (w_ss_edge)      w_state_nxt = ST_PAUSE;
        else if (w_lr_edge) w_state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (w_ss_edge)      w_state_nxt = ST_RUN;
        else if (w_lr_edge) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ticks are qualified by the registered (pre-transition) state
  assign w_cnt_en  = tick_100 & is_counting(r_state);

  // Lap/reset out of PAUSE clears the count on the same edge it goes IDLE
  assign w_cnt_clr = (r_state == ST_PAUSE) & w_lr_edge & ~w_ss_edge;

  bcd_cnt u_cs_ones (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_cnt_en),
    .i_clr   (w_cnt_clr),
    .i_max   (CS_MAX),
    .o_val   (w_count.cs_ones),
    .o_carry (w_c_cs_ones)
  );

  bcd_cnt u_cs_tens (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_c_cs_ones),
    .i_clr   (w_cnt_clr),
    .i_max   (CS_MAX),
    .o_val   (w_count.cs_tens),
    .o_carry (w_c_cs_tens)
  );

  bcd_cnt u_sec_ones (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_c_cs_tens),
    .i_clr   (w_cnt_clr),
    .i_max   (SEC_ONES_MAX),
    .o_val   (w_count.sec_ones),
    .o_carry (w_c_sec_ones)
  );

  bcd_cnt u_sec_tens (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_c_sec_ones),
    .i_clr   (w_cnt_clr),
    .i_max   (SEC_TENS_MAX),
    .o_val   (w_count.sec_tens),
    .o_carry (w_c_sec_tens)
  );

  // Wrap pulse: the top digit's carry is exactly the 59.99 -> 00.00 step,
  // registered so it is high during the cycle the count reads 00.00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_c_sec_tens;
    end
  end

  // Display register: follows the live count, but holds while in LAP.
  // The edge entering LAP still sees RUN here, which captures the lap time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp <= 16'h0000;
    end else if (r_state != ST_LAP) begin
      r_disp <= w_count;
    end
  end

  assign disp_bcd = r_disp;
  assign state    = r_state;
  assign running  = is_counting(r_state);
  assign wrap     = r_wrap;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 clk  input  1  system clock (crystal domain); all logic on posedge clk.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 tick_100  input  1  one-clk-wide 100 Hz enable pulse, synchronous to clk.
REQ-004 btn_ss  input  1  start/stop button, debounced level, synchronous to clk.
REQ-005 btn_lr  input  1  lap/reset button, debounced level, synchronous to clk.
REQ-006 disp_bcd  output  16  display digits {sec_tens, sec_ones, cs_tens, cs_ones}, BCD, 4 bits each.
REQ-007 state  output  2  current FSM state encoding.
REQ-008 running  output  1  high in RUN or LAP.
REQ-009 wrap  output  1  one-clk pulse when count rolls 59.99 -> 00.00.

Function
REQ-010 Button edge = btn & ~btn_q, where btn_q is the input registered one clk earlier; only rising edges act; a held button acts once.
REQ-011 The FSM SHALL have states IDLE=0, RUN=1, PAUSE=2, LAP=3, updated on the clk edge where the qualifying button edge is true.
REQ-012 IDLE: ss edge -> RUN; lr edge ignored.
REQ-013 RUN: ss edge -> PAUSE; lr edge -> LAP (freeze display).
REQ-014 LAP: count continues; ss edge -> PAUSE (display returns to live count); lr edge -> RUN (display returns to live count).
REQ-015 PAUSE: ss edge -> RUN; lr edge -> IDLE and count cleared to 00.00 on the same clk edge.
REQ-016 Simultaneous ss and lr edges: ss wins, lr edge discarded.
REQ-017 Count increments by 0.01 s on each clk where tick_100=1 and registered state is RUN or LAP; tick in the cycle of a transition uses the pre-transition state.
REQ-018 Digit rules: cs_ones 0-9, carry to cs_tens 0-9, carry to sec_ones 0-9, carry to sec_tens 0-5; no digit ever holds a value above its limit.
REQ-019 At 59.99 with an accepted tick: count -> 00.00 and wrap=1 for exactly the following clk cycle; FSM state unchanged.
REQ-020 disp_bcd is a register loaded with the live count every clk (one clk latency) except in LAP, where it holds the value captured at the clk edge entering LAP.
REQ-021 Clear in REQ-015 takes priority over a coincident tick; disp_bcd shows 0000 one clk later.
REQ-022 running and state are decoded from the registered state, no additional latency.

Reset
REQ-023 rst_n low SHALL asynchronously force state=IDLE, count=0000, disp_bcd=16'h0000, wrap=0, running=0, btn_q=0 for both buttons.
REQ-024 Reset mid-RUN or mid-LAP SHALL discard count and lap capture; after release, a button held high through reset SHALL NOT generate an edge until released and pressed again... except btn_q=0 means held-high registers an edge on the first clk -- required behaviour: btn_q resets to 0 and a held button DOES act once on the first post-reset clk.

Structure
REQ-025 State encodings and digit limits (CS_MAX=9, SEC_TENS_MAX=5) SHALL live in the shared global include alongside the divider constants.
REQ-026 One sub-module bcd_cnt (single BCD digit: enable in, programmable max, carry out, sync clear) SHALL be instantiated four times in a carry chain.
REQ-027 No derived clocks; tick_100 used only as enable.

Verification
REQ-028 Reset, ss pulse, 150 ticks -> state=RUN, disp_bcd=16'h0150 one clk after last tick, running=1.
REQ-029 RUN at 12.34, lr pulse, 100 ticks -> state=LAP, disp_bcd holds 16'h1234, internal count 13.34; lr pulse -> disp_bcd=16'h1334 next clk.
REQ-030 Preload 59.98 in RUN, 2 ticks -> disp_bcd 5999 then 0000; wrap high exactly one clk.
REQ-031 PAUSE at 07.00, ticks continue -> count static; lr pulse coincident with tick -> state=IDLE, disp_bcd=0000.
REQ-032 ss and lr rising same clk in RUN -> state=PAUSE, no lap capture; ss held high 1000 clk -> no further transitions.
REQ-033 Assert rst_n low mid-LAP between clk edges -> outputs zero immediately without waiting for clk.
